// File: rtl/add_sched_pkg.sv
// Shared types and arbitration helper for the round-robin adder scheduler.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a; rr_pick only decides among currently valid requesters.
package add_sched_pkg;

  // Result-register occupancy: IDLE = empty, FULL = holding a valid result.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // rr_pick works on a fixed-width vector; callers zero-extend into it.
  // The upper bit must stay unused, so NREQ is limited to MAX_NREQ-1.
  localparam int MAX_NREQ = 16;
  localparam int PTR_W    = 4;

  // One-hot grant to the first valid requester at or after ptr, modulo nreq.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [PTR_W-1:0]    ptr,
    input logic [PTR_W:0]      nreq
  );
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    logic [PTR_W:0]      idx;
    logic [PTR_W:0]      k_l;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      k_l = (PTR_W+1)'(k);
      idx = {1'b0, ptr} + k_l;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (k_l < nreq) && valid[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/add_unit.sv
// Registered WIDTH-bit adder with load enable; carry kept in sum[WIDTH].
// Latency: one cycle from load to sum/id.
// Backpressure: none; holds its value whenever load is low.
module add_unit #(
  parameter int WIDTH = 4,
  parameter int IDW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [IDW-1:0]   i_id,
  output logic [WIDTH:0]   o_sum,
  output logic [IDW-1:0]   o_id
);

  logic [WIDTH:0] r_sum;
  logic [IDW-1:0] r_id;

  // Capture the zero-extended sum and its tag on load; clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_id  <= '0;
    end else if (i_load) begin
      r_sum <= {1'b0, i_a} + {1'b0, i_b};
      r_id  <= i_id;
    end
  end

  assign o_sum = r_sum;
  assign o_id  = r_id;

endmodule

// File: rtl/add_rr_scheduler.sv
// Round-robin share of one registered adder between NREQ valid/ready requesters.
// Latency: one cycle from handshake to tagged result on res_*.
// Backpressure: a held result with res_ready low blocks every grant; consume+grant same cycle.
module add_rr_scheduler
  import add_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [WIDTH:0]        res_sum,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic [7:0]            op_count
);

  localparam logic [PTR_W:0] NREQ_L = (PTR_W+1)'(NREQ);

  state_e               r_state;
  logic [IDW-1:0]       r_ptr;
  logic [7:0]           r_count;

  logic                 w_can_accept;
  logic                 w_consume;
  logic [MAX_NREQ-1:0]  w_valid_ext;
  logic [PTR_W-1:0]     w_ptr_ext;
  logic [MAX_NREQ-1:0]  w_pick;
  logic [NREQ-1:0]      w_grant;
  logic                 w_any_grant;
  logic [IDW-1:0]       w_gid;
  logic [IDW-1:0]       w_ptr_next;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic                 w_pick_unused;

  // A new operand pair fits when the result register is empty or drains this cycle.
  assign w_can_accept = (r_state == ST_IDLE) | res_ready;
  assign w_consume    = (r_state == ST_FULL) & res_ready;

  // Widen request vector and pointer to the helper's fixed width.
  always_comb begin
    w_valid_ext = '0;
    w_valid_ext[NREQ-1:0] = req_valid;
    w_ptr_ext = '0;
    w_ptr_ext[IDW-1:0] = r_ptr;
  end

  assign w_pick        = rr_pick(w_valid_ext, w_ptr_ext, NREQ_L);
  assign w_pick_unused = ^w_pick[MAX_NREQ-1:NREQ];

  // Grants are suppressed in reset so nothing is handshaken that reset would then drop.
  assign w_grant     = (rst_n && w_can_accept) ? w_pick[NREQ-1:0] : '0;
  assign w_any_grant = |w_grant;
  assign req_ready   = w_grant;

  // Encode the one-hot grant into the requester index.
  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gid = IDW'(i);
    end
  end

  assign w_ptr_next = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
  assign w_a        = req_a[w_gid*WIDTH +: WIDTH];
  assign w_b        = req_b[w_gid*WIDTH +: WIDTH];

  // Occupancy state, round-robin pointer and consumed-result counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      if (w_consume) r_count <= r_count + 8'd1;
      if (w_any_grant) begin
        r_state <= ST_FULL;
        r_ptr   <= w_ptr_next;
      end else if (w_consume) begin
        r_state <= ST_IDLE;
      end
    end
  end

  add_unit #(
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_any_grant),
    .i_a   (w_a),
    .i_b   (w_b),
    .i_id  (w_gid),
    .o_sum (res_sum),
    .o_id  (res_id)
  );

  assign res_valid = (r_state == ST_FULL);
  assign op_count  = r_count;

endmodule

// File: tb/tb_add_rr_scheduler.sv
module tb_add_rr_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [WIDTH:0]        res_sum;
  logic [IDW-1:0]        res_id;
  logic                  res_ready;
  logic [7:0]            op_count;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: each entry = id*64 + sum
  int sb[$];
  int exp_ptr   = 0;
  int exp_count = 0;
  int cons_total = 0;

  add_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_sum  (res_sum),
    .res_id   (res_id),
    .res_ready(res_ready),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference monitor: sampled at negedge, i.e. the state seen by the next posedge.
  always @(negedge clk) begin
    int exp_grant;
    int g;
    int a_v;
    int b_v;
    int ent;
    if (!rst_n) begin
      check("rst_ready", 32'(req_ready), 32'd0);
      sb.delete();
      exp_ptr   = 0;
      exp_count = 0;
    end else begin
      check("res_valid", 32'(res_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
      check("op_count", 32'(op_count), 32'(exp_count % 256));
      exp_grant = 0;
      g = -1;
      if ((sb.size() == 0) || res_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          if ((g < 0) && req_valid[(exp_ptr + k) % NREQ]) g = (exp_ptr + k) % NREQ;
        end
        if (g >= 0) exp_grant = 1 << g;
      end
      check("req_ready", 32'(req_ready), 32'(exp_grant));
      if (res_valid && res_ready && (sb.size() != 0)) begin
        ent = sb.pop_front();
        check("res_sum", 32'(res_sum), 32'(ent % 64));
        check("res_id", 32'(res_id), 32'(ent / 64));
        exp_count++;
        cons_total++;
      end
      if (g >= 0) begin
        a_v = int'(req_a[g*WIDTH +: WIDTH]);
        b_v = int'(req_b[g*WIDTH +: WIDTH]);
        sb.push_back(g * 64 + a_v + b_v);
        exp_ptr = (g + 1) % NREQ;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0] held_sum;
    int gap;
    int max_gap;
    int budget;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_sum", 32'(res_sum), 32'd0);
    check("reset_res_id", 32'(res_id), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;

    // T1: grant then reset mid-op
    req_valid = 2'b01;
    req_a = {4'd0, 4'd3};
    req_b = {4'd0, 4'd4};
    tick();
    req_valid = '0;
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_sum", 32'(res_sum), 32'd7);
    rst_n = 1'b0;
    tick();
    check("t1_rst_valid", 32'(res_valid), 32'd0);
    check("t1_rst_count", 32'(op_count), 32'd0);
    check("t1_rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // T2: carry out
    res_ready = 1'b1;
    req_valid = 2'b01;
    req_a = {4'd0, 4'd15};
    req_b = {4'd0, 4'd15};
    tick();
    req_valid = '0;
    check("t2_sum", 32'(res_sum), 32'h1E);
    check("t2_id", 32'(res_id), 32'd0);
    check("t2_valid", 32'(res_valid), 32'd1);
    tick();
    check("t2_count", 32'(op_count), 32'd1);
    check("t2_drained", 32'(res_valid), 32'd0);

    // T3: round-robin from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_a = {4'd9, 4'd2};
    req_b = {4'd5, 4'd7};
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("t3_id", 32'(res_id), 32'(k % 2));
      check("t3_valid", 32'(res_valid), 32'd1);
      check("t3_sum", 32'(res_sum), (k % 2 == 0) ? 32'd9 : 32'd14);
    end

    // T4: backpressure with both requesters waiting
    res_ready = 1'b0;
    held_sum = res_sum;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_ready_blocked", 32'(req_ready), 32'd0);
      tick();
      check("t4_sum_hold", 32'(res_sum), 32'(held_sum));
      check("t4_id_hold", 32'(res_id), 32'd1);
      check("t4_valid_hold", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_regrant", 32'(req_ready), 32'd1);
    tick();
    check("t4_valid_stays", 32'(res_valid), 32'd1);
    check("t4_new_id", 32'(res_id), 32'd0);

    // T5: fairness, req1 always valid, req0 on odd cycles only
    gap = 0;
    max_gap = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = {1'b1, (c % 2 == 1) ? 1'b1 : 1'b0};
      req_a = {4'(c), 4'(c + 3)};
      req_b = {4'(c + 1), 4'(2)};
      @(negedge clk);
      if (req_ready[1]) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      tick();
    end
    check("t5_req1_not_starved", (max_gap <= 1) ? 32'd1 : 32'd0, 32'd1);

    // T6: op_count wrap
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    cons_total = 0;
    req_valid = 2'b01;
    req_a = {4'd0, 4'd1};
    req_b = {4'd0, 4'd2};
    res_ready = 1'b1;
    budget = 0;
    while ((cons_total < 256) && (budget < 600)) begin
      tick();
      budget++;
    end
    check("t6_reached_256", (cons_total == 256) ? 32'd1 : 32'd0, 32'd1);
    check("t6_wrap_zero", 32'(op_count), 32'd0);
    budget = 0;
    while ((cons_total < 257) && (budget < 10)) begin
      tick();
      budget++;
    end
    check("t6_reached_257", (cons_total == 257) ? 32'd1 : 32'd0, 32'd1);
    check("t6_count_one", 32'(op_count), 32'd1);
    req_valid = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
